// File: rtl/nn_parameters.sv
// rtl/nn_parameters.sv - shared network sizes and types for the classifier back end
package nn_parameters;

  localparam int OUT_SIZE_3  = 10;
  localparam int CLASS_IDX_W = $clog2(OUT_SIZE_3);

  typedef logic signed [39:0] score_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } decoder_state_t;

endpackage

// File: rtl/nn_class_decoder.sv
// rtl/nn_class_decoder.sv - argmax decoder over the final dense-layer scores with a margin-based confidence flag
module nn_class_decoder
  import nn_parameters::*;
#(
  parameter int                     NUM_CLASSES = OUT_SIZE_3,
  parameter int                     DATA_W      = 40,
  parameter int                     IDX_W       = $clog2(NUM_CLASSES),
  parameter logic signed [DATA_W:0] MIN_MARGIN  = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_CLASSES*DATA_W-1:0] score_vector,
  output logic                          busy,
  output logic                          done,
  output logic [IDX_W-1:0]              class_idx,
  output logic signed [DATA_W-1:0]      class_score,
  output logic signed [DATA_W:0]        margin,
  output logic                          confident
);

  localparam logic signed [DATA_W-1:0] MIN_SCORE = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NUM_CLASSES - 1);

  decoder_state_t state_q, state_d;

  logic signed [DATA_W-1:0] score_buf [NUM_CLASSES];
  logic [IDX_W-1:0]         i_q;
  logic signed [DATA_W-1:0] best_q, best_d;
  logic signed [DATA_W-1:0] second_q, second_d;
  logic [IDX_W-1:0]         best_idx_q, best_idx_d;
  logic signed [DATA_W-1:0] x;
  logic signed [DATA_W:0]   margin_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (i_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strict '>' on best keeps ties at the lowest index; an equal value still lands in second.
  always_comb begin
    x          = score_buf[i_q];
    best_d     = best_q;
    second_d   = second_q;
    best_idx_d = best_idx_q;
    if (i_q == '0) begin
      best_d     = x;
      best_idx_d = '0;
      second_d   = MIN_SCORE;
    end else if (x > best_q) begin
      second_d   = best_q;
      best_d     = x;
      best_idx_d = i_q;
    end else if (x > second_q) begin
      second_d = x;
    end
    margin_d = {best_d[DATA_W-1], best_d} - {second_d[DATA_W-1], second_d};
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        score_buf[k] <= score_vector[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      i_q         <= '0;
      best_q      <= '0;
      second_q    <= '0;
      best_idx_q  <= '0;
      class_idx   <= '0;
      class_score <= '0;
      margin      <= '0;
      confident   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) i_q <= '0;
        SCAN: begin
          best_q     <= best_d;
          second_q   <= second_d;
          best_idx_q <= best_idx_d;
          // Results are captured on the last scan edge so they are already valid in the DONE cycle.
          if (i_q == LAST_IDX) begin
            class_idx   <= best_idx_d;
            class_score <= best_d;
            margin      <= margin_d;
            confident   <= (margin_d >= MIN_MARGIN);
          end else begin
            i_q <= i_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
